// File: rtl/nios2_cpu_oci_dct_sequencer.sv
// nios2_cpu_oci_dct_sequencer
//
// Controller for the OCI data-capture-trace packing buffer. Trace fragments
// are shifted into a FRAG_W*FRAGS-bit buffer, with the oldest fragment ending
// up at the MSB end. A full word, or a flushed partial word, is handed to the
// trace store over a valid/ready handshake. end_req starts a drain that emits
// any remaining fragments and then parks in a terminal state until reset.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   frag_valid/frag_data  fragment offer from the trace front-end
//   frag_ready            fragment accepted when frag_valid & frag_ready
//   flush_req             level, emit the current partial word
//   end_req               level, begin end-of-test drain
//   out_valid/out_ready   packed word handshake to the trace store
//   out_data/out_count    packed word and number of valid low-order fragments
//   dct_buffer/dct_count  live packing buffer and fragment count
//   test_ending           drain in progress
//   test_has_ended        drain complete, sticky until reset
//   stall_cnt             (DCT_STALL_CNT_EN only) saturating count of cycles
//                         with frag_valid=1 and frag_ready=0
//
// Optional feature macro: DCT_STALL_CNT_EN

module nios2_cpu_oci_dct_sequencer #(
    parameter int FRAG_W = 6,
    parameter int FRAGS  = 5,
    parameter int CNT_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frag_valid,
    input  logic [FRAG_W-1:0]         frag_data,
    output logic                      frag_ready,
    input  logic                      flush_req,
    input  logic                      end_req,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FRAG_W*FRAGS-1:0]   out_data,
    output logic [CNT_W-1:0]          out_count,
    output logic [FRAG_W*FRAGS-1:0]   dct_buffer,
    output logic [CNT_W-1:0]          dct_count,
    output logic                      test_ending,
`ifdef DCT_STALL_CNT_EN
    output logic                      test_has_ended,
    output logic [15:0]               stall_cnt
`else
    output logic                      test_has_ended
`endif
);

    localparam int BUF_W = FRAG_W * FRAGS;

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        ENDING,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [BUF_W-1:0]    out_data_q, out_data_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;
    logic                test_ending_q, test_ending_d;
    logic                test_has_ended_q, test_has_ended_d;

    logic                accept;
    logic [BUF_W-1:0]    buf_acc;
    logic [CNT_W-1:0]    cnt_acc;

    assign frag_ready = (state_q == FILL);
    assign accept     = frag_valid & frag_ready;

    always_comb begin
        // Buffer and count as they stand after this cycle's accept; the
        // FILL exit decision and the emitted word both use these values so a
        // fragment arriving with flush_req/end_req is included.
        buf_acc = buf_q;
        cnt_acc = cnt_q;
        if (accept) begin
            buf_acc = {buf_q[BUF_W-FRAG_W-1:0], frag_data};
            cnt_acc = cnt_q + CNT_W'(1);
        end

        state_d          = state_q;
        buf_d            = buf_q;
        cnt_d            = cnt_q;
        out_valid_d      = out_valid_q;
        out_data_d       = out_data_q;
        out_count_d      = out_count_q;
        test_ending_d    = test_ending_q;
        test_has_ended_d = test_has_ended_q;

        case (state_q)
            FILL: begin
                buf_d = buf_acc;
                cnt_d = cnt_acc;
                if (cnt_acc == CNT_W'(FRAGS)) begin
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    out_data_d  = buf_acc;
                    out_count_d = cnt_acc;
                end else if (end_req) begin
                    state_d       = ENDING;
                    test_ending_d = 1'b1;
                end else if (flush_req && (cnt_acc != '0)) begin
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    out_data_d  = buf_acc;
                    out_count_d = cnt_acc;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    buf_d       = '0;
                    cnt_d       = '0;
                    if (end_req || test_ending_q) begin
                        state_d       = ENDING;
                        test_ending_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            ENDING: begin
                if (cnt_q != '0) begin
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    out_data_d  = buf_q;
                    out_count_d = cnt_q;
                end else begin
                    state_d          = DONE;
                    test_ending_d    = 1'b0;
                    test_has_ended_d = 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= FILL;
            buf_q            <= '0;
            cnt_q            <= '0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_count_q      <= '0;
            test_ending_q    <= 1'b0;
            test_has_ended_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            buf_q            <= buf_d;
            cnt_q            <= cnt_d;
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            out_count_q      <= out_count_d;
            test_ending_q    <= test_ending_d;
            test_has_ended_q <= test_has_ended_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_count      = out_count_q;
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign test_ending    = test_ending_q;
    assign test_has_ended = test_has_ended_q;

`ifdef DCT_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (frag_valid && !frag_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_nios2_cpu_oci_dct_sequencer.sv
// Testbench for nios2_cpu_oci_dct_sequencer: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model built
// from a fragment queue, a held-word slot and drain/ended flags.

module tb_nios2_cpu_oci_dct_sequencer;

    localparam int FRAG_W = 6;
    localparam int FRAGS  = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              frag_valid = 1'b0;
    logic [FRAG_W-1:0] frag_data = '0;
    logic              frag_ready;
    logic              flush_req = 1'b0;
    logic              end_req = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [29:0]       out_data;
    logic [CNT_W-1:0]  out_count;
    logic [29:0]       dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              test_ending;
    logic              test_has_ended;
`ifdef DCT_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    nios2_cpu_oci_dct_sequencer #(
        .FRAG_W(FRAG_W),
        .FRAGS (FRAGS),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frag_valid    (frag_valid),
        .frag_data     (frag_data),
        .frag_ready    (frag_ready),
        .flush_req     (flush_req),
        .end_req       (end_req),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_count     (out_count),
        .dct_buffer    (dct_buffer),
        .dct_count     (dct_count),
        .test_ending   (test_ending),
`ifdef DCT_STALL_CNT_EN
        .test_has_ended(test_has_ended),
        .stall_cnt     (stall_cnt)
`else
        .test_has_ended(test_has_ended)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [FRAG_W-1:0] mq[$];      // fragments currently in the buffer, oldest first
    bit                m_held;     // a word is offered to the trace store
    logic [29:0]       m_od;
    int                m_oc;
    bit                m_drain;
    bit                m_ended;
    int                m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [29:0] pack_q();
        logic [29:0] acc = '0;
        foreach (mq[i]) acc = (acc << FRAG_W) | 30'(mq[i]);
        return acc;
    endfunction

    function automatic bit m_ready();
        return !m_held && !m_drain && !m_ended;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_held  = 0;
        m_od    = '0;
        m_oc    = 0;
        m_drain = 0;
        m_ended = 0;
        m_stall = 0;
    endtask

    task automatic model_emit();
        m_held = 1;
        m_od   = pack_q();
        m_oc   = mq.size();
    endtask

    // One clock of the model, using the inputs that were sampled on the edge.
    task automatic model_step();
        if (frag_valid && !m_ready() && m_stall < 65535) m_stall++;
        if (m_ended) begin
            // terminal
        end else if (m_ready()) begin
            if (frag_valid) mq.push_back(frag_data);
            if (mq.size() == FRAGS) model_emit();
            else if (end_req) m_drain = 1;
            else if (flush_req && mq.size() > 0) model_emit();
        end else if (m_held) begin
            if (out_ready) begin
                m_held = 0;
                mq.delete();
                if (end_req || m_drain) m_drain = 1;
            end
        end else begin
            if (mq.size() > 0) model_emit();
            else begin
                m_drain = 0;
                m_ended = 1;
            end
        end
    endtask

    task automatic check_all();
        check("frag_ready", 32'(frag_ready), 32'(m_ready()));
        check("out_valid", 32'(out_valid), 32'(m_held));
        check("out_data", 32'(out_data), 32'(m_od));
        check("out_count", 32'(out_count), 32'(m_oc));
        check("dct_buffer", 32'(dct_buffer), 32'(pack_q()));
        check("dct_count", 32'(dct_count), 32'(mq.size()));
        check("test_ending", 32'(test_ending), 32'(m_drain));
        check("test_has_ended", 32'(test_has_ended), 32'(m_ended));
`ifdef DCT_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    task automatic cycle(input bit fv, input logic [FRAG_W-1:0] fd, input bit fl,
                         input bit er, input bit ordy);
        @(negedge clk);
        frag_valid = fv;
        frag_data  = fd;
        flush_req  = fl;
        end_req    = er;
        out_ready  = ordy;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Reset lands between clock edges; the registered outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        frag_valid = 1'b0;
        flush_req  = 1'b0;
        end_req    = 1'b0;
        out_ready  = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_dct_buffer", 32'(dct_buffer), 32'd0);
        check("rst_dct_count", 32'(dct_count), 32'd0);
        check("rst_test_ending", 32'(test_ending), 32'd0);
        check("rst_test_has_ended", 32'(test_has_ended), 32'd0);
        check("rst_frag_ready", 32'(frag_ready), 32'd1);
`ifdef DCT_STALL_CNT_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Five fragments back-to-back with the store ready.
        for (int i = 1; i <= 5; i++) cycle(1, 6'(i), 0, 0, 1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h01083105);
        check("t1_count", 32'(out_count), 32'd5);
        cycle(0, '0, 0, 0, 1);
        check("t1_cnt_clear", 32'(dct_count), 32'd0);

        // Store back-pressure for 10 cycles while fragments keep coming.
        for (int i = 0; i < 5; i++) cycle(1, 6'($urandom), 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 6'h15, 0, 0, 0);
        cycle(0, '0, 0, 0, 1);
        check("t2_fill_again", 32'(frag_ready), 32'd1);

        // Flush a partial word, then flush with nothing buffered.
        cycle(1, 6'h3F, 0, 0, 0);
        cycle(1, 6'h2A, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        check("t3_data", 32'(out_data), 32'h00000FEA);
        check("t3_count", 32'(out_count), 32'd2);
        cycle(0, '0, 0, 0, 1);
        cycle(0, '0, 1, 0, 1);
        check("t3_empty_flush", 32'(out_valid), 32'd0);

        // end_req arriving with the fourth fragment.
        for (int i = 0; i < 3; i++) cycle(1, 6'(i + 7), 0, 0, 0);
        cycle(1, 6'h0A, 0, 1, 0);
        check("t4_ending", 32'(test_ending), 32'd1);
        cycle(0, '0, 0, 0, 0);
        check("t4_count", 32'(out_count), 32'd4);
        cycle(0, '0, 0, 0, 1);
        cycle(0, '0, 0, 0, 0);
        check("t4_ended", 32'(test_has_ended), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1, 6'h11, 1, 1, 1);

        // end_req with an empty buffer.
        do_reset();
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 0, 0);
        check("t5_ended", 32'(test_has_ended), 32'd1);
        check("t5_no_word", 32'(out_valid), 32'd0);

        // Reset while a word is being offered.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 6'(i + 33), 0, 0, 0);
        do_reset();

`ifdef DCT_STALL_CNT_EN
        // Seven stalled cycles during an EMIT.
        for (int i = 0; i < 5; i++) cycle(1, 6'(i), 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1, 6'h01, 0, 0, 0);
        check("t6_stall", 32'(stall_cnt), 32'd7);
        cycle(0, '0, 0, 0, 1);
        do_reset();
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            else cycle($urandom_range(0, 9) < 7, 6'($urandom), $urandom_range(0, 9) == 0,
                       $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
